// File: rtl/ifetch_unit_pkg.sv
// Shared constants and types for the ifetch_unit fetch stage.
package ifetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_HOLD  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_word_t;

endpackage

// File: rtl/ifetch_unit_perf.sv
// Free-running wrap-around counters for fetched words and cache wait cycles.
module ifetch_perf_counters
  import ifetch_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_fetched,
  input  logic            inc_wait,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_wait_cycles
);

  logic [XLEN-1:0] fetched_q, fetched_d;
  logic [XLEN-1:0] wait_q, wait_d;

  always_comb begin
    fetched_d = fetched_q;
    wait_d    = wait_q;
    if (inc_fetched) fetched_d = fetched_q + XLEN'(1);
    if (inc_wait)    wait_d    = wait_q + XLEN'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      wait_q    <= '0;
    end else begin
      fetched_q <= fetched_d;
      wait_q    <= wait_d;
    end
  end

  assign perf_fetched     = fetched_q;
  assign perf_wait_cycles = wait_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage + IF/ID register: one outstanding I-cache request, stall hold,
// redirect flush and stale-response drop. IFETCH_PERF_EN adds perf counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic             clock,
  input  logic             reset,
  output logic             icache_req_valid,
  output logic [XLEN-1:0]  icache_req_addr,
  input  logic             icache_req_ready,
  input  logic             icache_resp_valid,
  input  logic [XLEN-1:0]  icache_resp_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
`ifdef IFETCH_PERF_EN
  output logic [XLEN-1:0]  perf_fetched,
  output logic [XLEN-1:0]  perf_wait_cycles,
`endif
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_instr,
  output logic [OPC_W-1:0] id_opcode
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  fetch_word_t     id_q, id_d;
  fetch_word_t     hold_q, hold_d;
  logic            load_id;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;
  fetch_word_t     resp_word;
  fetch_word_t     empty_word;

  assign redir_pc   = redirect_pc & ~XLEN'(3);
  assign pc_inc     = pc_q + XLEN'(4);
  assign resp_word  = '{pc: pc_q, instr: icache_resp_data};
  assign empty_word = '{pc: '0, instr: NOP_INSTR};

  // Next-state, PC and pipeline-register update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    id_valid_d = id_valid_q;
    id_d       = id_q;
    load_id    = 1'b0;

    unique case (state_q)
      IF_FETCH: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (icache_req_ready) state_d = IF_DROP;
        end else if (icache_req_ready) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (icache_resp_valid) begin
          state_d = IF_FETCH;
          if (redirect_valid) begin
            pc_d = redir_pc;
          end else if (!stall || !id_valid_q) begin
            load_id = 1'b1;
            id_d    = resp_word;
            pc_d    = pc_inc;
          end else begin
            hold_d  = resp_word;
            state_d = IF_HOLD;
          end
        end else if (redirect_valid) begin
          // Request still in flight: its response must be thrown away.
          pc_d    = redir_pc;
          state_d = IF_DROP;
        end
      end
      IF_HOLD: begin
        if (redirect_valid) begin
          hold_d  = empty_word;
          pc_d    = redir_pc;
          state_d = IF_FETCH;
        end else if (!stall) begin
          load_id = 1'b1;
          id_d    = hold_q;
          hold_d  = empty_word;
          pc_d    = pc_inc;
          state_d = IF_FETCH;
        end
      end
      IF_DROP: begin
        if (redirect_valid)    pc_d    = redir_pc;
        if (icache_resp_valid) state_d = IF_FETCH;
      end
    endcase

    // Redirect flushes ahead of stall; an idle, unstalled register drains to NOP
    if (load_id) begin
      id_valid_d = 1'b1;
    end else if (redirect_valid || !stall) begin
      id_valid_d = 1'b0;
      id_d.instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_q       <= '{pc: '0, instr: NOP_INSTR};
      hold_q     <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
      hold_q     <= hold_d;
    end
  end

  assign icache_req_valid = (state_q == IF_FETCH);
  assign icache_req_addr  = pc_q;
  assign id_valid         = id_valid_q;
  assign id_pc            = id_q.pc;
  assign id_instr         = id_q.instr;
  assign id_opcode        = id_q.instr[OPC_W-1:0];

`ifdef IFETCH_PERF_EN
  ifetch_perf_counters u_perf (
    .clock            (clock),
    .reset            (reset),
    .inc_fetched      (load_id),
    .inc_wait         ((state_q == IF_WAIT) || (state_q == IF_DROP)),
    .perf_fetched     (perf_fetched),
    .perf_wait_cycles (perf_wait_cycles)
  );
`endif

endmodule
